color_grade_lut: RTL

//   Per-channel colour-grading stage directly downstream of framebuffer scanout. Takes the RGB888

---
 rtl/color_grade_lut_if.sv | 30 +++
 rtl/color_grade_lut.sv | 129 ++++++++++++
 2 files changed

// File: rtl/color_grade_lut_if.sv
// SRAM burst-read bus between the LUT loader (master) and the memory arbiter (slave).
interface color_grade_lut_if;
  logic        sram_req;
  logic [23:0] sram_addr;
  logic [7:0]  sram_burst_len;
  logic        sram_ready;
  logic        sram_ack;
  logic [15:0] sram_burst_rdata;
  logic        sram_burst_data_valid;

  modport master (
    output sram_req,
    output sram_addr,
    output sram_burst_len,
    input  sram_ready,
    input  sram_ack,
    input  sram_burst_rdata,
    input  sram_burst_data_valid
  );

  modport slave (
    input  sram_req,
    input  sram_addr,
    input  sram_burst_len,
    output sram_ready,
    output sram_ack,
    output sram_burst_rdata,
    output sram_burst_data_valid
  );
endinterface

// File: rtl/color_grade_lut.sv
// Per-channel colour grading: three 64-entry tables, reloaded by one SRAM burst at vsync,
// remap the RGB888 scanout stream on each pixel_tick.
module color_grade_lut (
  input  logic              clk_sram,
  input  logic              rst_n_sram,
  input  logic              pixel_tick,
  input  logic              vsync_in,
  input  logic [7:0]        in_red,
  input  logic [7:0]        in_green,
  input  logic [7:0]        in_blue,
  input  logic              lut_enable,
  input  logic [23:0]       lut_base,
  input  logic              lut_load,
  color_grade_lut_if.master sram,
  output logic [7:0]        out_red,
  output logic [7:0]        out_green,
  output logic [7:0]        out_blue,
  output logic              lut_valid,
  output logic              lut_busy
);

  localparam int unsigned Entries    = 64;
  localparam int unsigned BurstWords = 3 * Entries;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  state_q;
  logic        req_q;
  logic [23:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_cnt_q;
  logic        load_pending_q;
  logic        vsync_prev_q;
  logic        valid_q;

  // R, G and B tables laid out back to back so the beat counter is the write address.
  logic [7:0]  tbl [BurstWords];

  logic        vs_rise;
  logic        beat_we;
  logic        use_lut;
  logic [7:0]  idx_red;
  logic [7:0]  idx_green;
  logic [7:0]  idx_blue;

  // Decode vsync edge, beat acceptance and table read addresses.
  always_comb begin
    vs_rise   = vsync_in & ~vsync_prev_q;
    beat_we   = (state_q == StReq) && sram.sram_burst_data_valid &&
                (beat_cnt_q < 8'(BurstWords));
    use_lut   = lut_enable & valid_q & ~lut_busy;
    idx_red   = {2'b00, in_red[7:2]};
    idx_green = 8'(Entries) + {2'b00, in_green[7:2]};
    idx_blue  = 8'(2 * Entries) + {2'b00, in_blue[7:2]};
  end

  assign sram.sram_req       = req_q;
  assign sram.sram_addr      = addr_q;
  assign sram.sram_burst_len = len_q;
  assign lut_valid           = valid_q;
  assign lut_busy            = (state_q != StIdle);

  // Load FSM: wait for a pending load at vsync, run the burst, then qualify the image.
  always_ff @(posedge clk_sram or negedge rst_n_sram) begin
    if (!rst_n_sram) begin
      state_q        <= StIdle;
      req_q          <= 1'b0;
      addr_q         <= '0;
      len_q          <= '0;
      beat_cnt_q     <= '0;
      load_pending_q <= 1'b0;
      vsync_prev_q   <= 1'b0;
      valid_q        <= 1'b0;
    end else begin
      vsync_prev_q <= vsync_in;
      if (lut_load) load_pending_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (vs_rise && load_pending_q && sram.sram_ready) begin
            state_q    <= StReq;
            req_q      <= 1'b1;
            addr_q     <= lut_base;
            len_q      <= 8'(BurstWords);
            beat_cnt_q <= '0;
            valid_q    <= 1'b0;
            // A load request arriving in this same cycle stays queued for the next frame.
            if (!lut_load) load_pending_q <= 1'b0;
          end
        end
        StReq: begin
          if (beat_we) beat_cnt_q <= beat_cnt_q + 8'd1;
          if (sram.sram_ack) begin
            req_q   <= 1'b0;
            len_q   <= '0;
            state_q <= StDone;
          end
        end
        StDone: begin
          valid_q <= (beat_cnt_q == 8'(BurstWords));
          // Short burst: retry automatically at the next frame.
          if (beat_cnt_q != 8'(BurstWords)) load_pending_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Table RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk_sram) begin
    if (beat_we) tbl[beat_cnt_q] <= sram.sram_burst_rdata[7:0];
  end

  // Pixel path: registered remap or bypass, updated only on pixel_tick.
  always_ff @(posedge clk_sram or negedge rst_n_sram) begin
    if (!rst_n_sram) begin
      out_red   <= '0;
      out_green <= '0;
      out_blue  <= '0;
    end else if (pixel_tick) begin
      out_red   <= use_lut ? tbl[idx_red]   : in_red;
      out_green <= use_lut ? tbl[idx_green] : in_green;
      out_blue  <= use_lut ? tbl[idx_blue]  : in_blue;
    end
  end

endmodule
